// File: rtl/cmd_assembler_pkg.sv
// cmd_pkg: shared command type, host word width, beat count and FSM state encoding for cmd_assembler.
// CMD_W follows cmd_t. BEATS is the number of host words that together cover one command.
package cmd_pkg;
  typedef logic [71:0] cmd_t;
  localparam int CMD_W = $bits(cmd_t);
  localparam int WORD_W = 32;
  localparam int BEATS = (CMD_W + WORD_W - 1) / WORD_W;
  localparam int CNT_W = 16;
  typedef enum logic {COLLECT, PUSH} state_e;
endpackage

// File: rtl/cmd_assembler_if.sv
// cmd_assembler_if: host word stream, command FIFO write side and status of cmd_assembler.
// master: host/FIFO side, which drives i_valid, i_word, i_abort and i_fifo_full.
// slave: assembler side, which drives o_ready, o_write, o_cmd, o_busy, o_cmd_count and o_err.
interface cmd_assembler_if;
  import cmd_pkg::*;
  logic i_valid;
  logic [WORD_W-1:0] i_word;
  logic o_ready;
  logic i_abort;
  logic o_write;
  cmd_t o_cmd;
  logic i_fifo_full;
  logic o_busy;
  logic [CNT_W-1:0] o_cmd_count;
  logic o_err;
  modport master (output i_valid, i_word, i_abort, i_fifo_full,
                  input o_ready, o_write, o_cmd, o_busy, o_cmd_count, o_err);
  modport slave (input i_valid, i_word, i_abort, i_fifo_full,
                 output o_ready, o_write, o_cmd, o_busy, o_cmd_count, o_err);
endinterface

// File: rtl/cmd_assembler.sv
// cmd_assembler: packs LSB-first host words into commands and writes each command into the command FIFO.
// Ports: i_clk; i_rstn (asynchronous, active-low); bus (slave): i_valid/i_word/o_ready/i_abort form the host stream,
// o_write/o_cmd/i_fifo_full form the FIFO write side, and o_busy/o_cmd_count/o_err report status.
// Option: CMD_ASM_CHECKSUM_EN adds a trailing XOR checksum word and the o_err pulse with an internal error counter.
module cmd_assembler
  import cmd_pkg::*;
(
  input logic i_clk,
  input logic i_rstn,
  cmd_assembler_if.slave bus
);
`ifdef CMD_ASM_CHECKSUM_EN
  localparam int NB = BEATS + 1;
`else
  localparam int NB = BEATS;
`endif
  localparam int BW = $clog2(NB);
  localparam logic [BW-1:0] LAST = BW'(NB - 1);
  state_e state, state_n;
  logic live, acc, fin, ok, write;
  logic [BW-1:0] beat;
  logic [BEATS*WORD_W-1:0] shreg, sh_n;
  cmd_t cmd_q, last_q;
  logic [CNT_W-1:0] count;
  // live holds o_ready low during reset and for the edge that releases it.
  assign bus.o_ready = live && state == COLLECT;
  // An abort in COLLECT wins over a beat presented in the same cycle.
  assign acc = bus.o_ready && bus.i_valid && !bus.i_abort;
  assign fin = acc && beat == LAST;
  assign bus.o_write = write;
  // o_cmd only moves when a write happens, so the FIFO sees stable data between pushes.
  assign bus.o_cmd = write ? cmd_q : last_q;
  assign bus.o_busy = beat != '0 || state == PUSH;
  assign bus.o_cmd_count = count;
`ifdef CMD_ASM_CHECKSUM_EN
  logic [WORD_W-1:0] csum;
  logic err_q;
  logic [CNT_W-1:0] err_cnt;
  // The checksum covers the full data words, including the unused high bits of the last one.
  always_comb begin
    csum = '0;
    for (int k = 0; k < BEATS; k++) csum ^= shreg[k*WORD_W +: WORD_W];
  end
  assign ok = csum == bus.i_word;
  assign bus.o_err = err_q;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      err_q <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_q <= fin && !ok;
      if (fin && !ok && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
`else
  assign ok = 1'b1;
  assign bus.o_err = 1'b0;
`endif
  // The checksum word never lands in the shift register; only data beats are stored.
  always_comb begin
    sh_n = shreg;
    if (beat < BW'(BEATS)) sh_n[beat*WORD_W +: WORD_W] = bus.i_word;
  end
  always_comb begin
    write = state == PUSH && !bus.i_fifo_full;
    state_n = state == PUSH ? (write ? COLLECT : PUSH) : (fin && ok ? PUSH : COLLECT);
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) state <= COLLECT;
    else state <= state_n;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      live <= 1'b0;
      beat <= '0;
      shreg <= '0;
      cmd_q <= '0;
      last_q <= '0;
      count <= '0;
    end else begin
      live <= 1'b1;
      if (state == COLLECT && bus.i_abort) begin
        beat <= '0;
        shreg <= '0;
      end else if (fin) begin
        beat <= '0;
        shreg <= '0;
        if (ok) cmd_q <= sh_n[CMD_W-1:0];
      end else if (acc) begin
        beat <= beat + 1'b1;
        shreg <= sh_n;
      end
      if (write) begin
        last_q <= cmd_q;
        if (count != '1) count <= count + 1'b1;
      end
    end
endmodule

// File: tb/tb_cmd_assembler.sv
// tb_cmd_assembler: directed and randomized checks of cmd_assembler against a queue-based command model.
module tb_cmd_assembler;
  logic clk = 0;
  logic rstn = 0;
  int errors = 0;
  int checks = 0;
  int nerr = 0;
  int exp_err = 0;
  int exp_cnt = 0;
  bit wr_full = 0;
  logic [71:0] got[$];
  logic [71:0] exp[$];
  logic [71:0] e;

  always #5 clk = ~clk;

  cmd_assembler_if bus();
  cmd_assembler dut (.i_clk(clk), .i_rstn(rstn), .bus(bus));

  always @(posedge clk)
    if (rstn) begin
      if (bus.o_write) got.push_back(bus.o_cmd);
      if (bus.o_write && bus.i_fifo_full) wr_full = 1;
      if (bus.o_err) nerr++;
    end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] xp);
    checks++;
    assert (obs === xp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, xp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_valid = 0;
      bus.i_abort = 0;
    end
  endtask

  task automatic send_beat(input logic [31:0] w, input bit ab);
    int n = 0;
    @(negedge clk);
    bus.i_valid = 1;
    bus.i_word = w;
    bus.i_abort = ab;
    do begin
      @(posedge clk);
      n++;
    end while (!bus.o_ready && n < 64);
    if (n >= 64) chk("beat_timeout", 0, 1);
  endtask

  task automatic send_cmd(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input bit gaps, input bit bad);
    logic [95:0] c;
    send_beat(w0, 0);
    if (gaps) idle($urandom_range(0, 3));
    send_beat(w1, 0);
    if (gaps) idle($urandom_range(0, 3));
    send_beat(w2, 0);
`ifdef CMD_ASM_CHECKSUM_EN
    if (gaps) idle($urandom_range(0, 3));
    send_beat(w0 ^ w1 ^ w2 ^ {31'b0, bad}, 0);
    if (bad) exp_err++;
`endif
    c = {w2, w1, w0};
    if (!bad) begin
      exp.push_back(c[71:0]);
      exp_cnt++;
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_writes"}, got.size(), exp.size());
    while (got.size() > 0 && exp.size() > 0) chk(tag, got.pop_front(), exp.pop_front());
    got.delete();
    exp.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    bus.i_valid = 0;
    bus.i_word = 0;
    bus.i_abort = 0;
    bus.i_fifo_full = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.o_ready, 0);
    chk("rst_write", bus.o_write, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_count", bus.o_cmd_count, 0);
    chk("rst_cmd", bus.o_cmd, 0);
    chk("rst_err", bus.o_err, 0);
    rstn = 1;
    @(negedge clk);
    chk("ready_after_rst", bus.o_ready, 1);

    send_cmd(32'h11111111, 32'h22222222, 32'h000000AB, 0, 0);
    @(negedge clk);
    bus.i_valid = 0;
    chk("basic_write", bus.o_write, 1);
    chk("basic_cmd", bus.o_cmd, 72'hAB_22222222_11111111);
    chk("basic_ready", bus.o_ready, 0);
    @(negedge clk);
    chk("basic_write_end", bus.o_write, 0);
    chk("basic_hold", bus.o_cmd, 72'hAB_22222222_11111111);
    chk("basic_count", bus.o_cmd_count, exp_cnt);
    chk("basic_busy", bus.o_busy, 0);
    check_writes("basic");

    bus.i_fifo_full = 1;
    send_cmd($urandom, $urandom, $urandom, 0, 0);
    e = exp[exp.size()-1];
    repeat (5) begin
      @(negedge clk);
      bus.i_valid = 0;
      chk("bp_write", bus.o_write, 0);
      chk("bp_ready", bus.o_ready, 0);
    end
    chk("bp_busy", bus.o_busy, 1);
    @(negedge clk);
    bus.i_fifo_full = 0;
    #1;
    chk("bp_release_write", bus.o_write, 1);
    chk("bp_release_cmd", bus.o_cmd, e);
    @(negedge clk);
    chk("bp_write_end", bus.o_write, 0);
    check_writes("bp");
    chk("bp_count", bus.o_cmd_count, exp_cnt);

    send_beat(32'hDEAD0001, 0);
    send_beat(32'hDEAD0002, 0);
    send_beat(32'hDEAD0003, 1);
    @(negedge clk);
    bus.i_valid = 0;
    bus.i_abort = 0;
    chk("abort_busy", bus.o_busy, 0);
    send_cmd(32'hA, 32'hB, 32'hC, 0, 0);
    idle(3);
    chk("abort_cmd", got.size() > 0 ? got[0] : 72'hx, 72'h0C_0000000B_0000000A);
    check_writes("abort");
    chk("abort_count", bus.o_cmd_count, exp_cnt);

    send_beat(32'h55555555, 0);
    @(negedge clk);
    bus.i_valid = 0;
    chk("mid_busy", bus.o_busy, 1);
    rstn = 0;
    #1;
    chk("mid_rst_ready", bus.o_ready, 0);
    chk("mid_rst_busy", bus.o_busy, 0);
    chk("mid_rst_count", bus.o_cmd_count, 0);
    chk("mid_rst_cmd", bus.o_cmd, 0);
    chk("mid_rst_write", bus.o_write, 0);
    exp_cnt = 0;
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    chk("mid_ready", bus.o_ready, 1);
    send_cmd(32'h01234567, 32'h89ABCDEF, 32'h00000042, 0, 0);
    idle(3);
    check_writes("rst_mid");
    chk("rst_mid_count", bus.o_cmd_count, exp_cnt);

    for (int i = 0; i < 10; i++) send_cmd($urandom, $urandom, $urandom, 1, 0);
    idle(4);
    check_writes("stream");
    chk("stream_count", bus.o_cmd_count, exp_cnt);

`ifdef CMD_ASM_CHECKSUM_EN
    send_cmd($urandom, $urandom, $urandom, 0, 0);
    idle(3);
    send_cmd($urandom, $urandom, $urandom, 0, 1);
    idle(3);
    check_writes("csum");
    chk("csum_count", bus.o_cmd_count, exp_cnt);
`endif
    chk("err_pulses", nerr, exp_err);
    chk("no_write_when_full", wr_full, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
